// File: rtl/rice_core_mul_ctrl.sv
// Request sequencer for the iterative radix-4 multiplier.
// Accepts one multiply request at a time, starts the multiplier with a
// single pulse, holds the operands for the whole iteration and hands the
// result back with the request tag. Flushes either drop the pending
// response or let an in-flight multiplication drain before going idle.

package rice_core_mul_pkg;
    typedef struct packed {
        logic rs1_signed;
        logic rs2_signed;
        logic rd_high;
    } rice_core_mul_operation;
endpackage

module rice_core_mul_ctrl
    import rice_core_mul_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int TAG_WIDTH   = 5,
    parameter bit ZERO_BYPASS = 1'b1
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_req_valid,
    output logic                   o_req_ready,
    input  logic [XLEN-1:0]        i_req_rs1,
    input  logic [XLEN-1:0]        i_req_rs2,
    input  rice_core_mul_operation i_req_operation,
    input  logic [TAG_WIDTH-1:0]   i_req_tag,
    input  logic                   i_flush,
    output logic                   o_mul_valid,
    output logic [XLEN-1:0]        o_mul_rs1_value,
    output logic [XLEN-1:0]        o_mul_rs2_value,
    output rice_core_mul_operation o_mul_operation,
    input  logic                   i_mul_result_valid,
    input  logic [XLEN-1:0]        i_mul_result,
    output logic                   o_rsp_valid,
    input  logic                   i_rsp_ready,
    output logic [XLEN-1:0]        o_rsp_result,
    output logic [TAG_WIDTH-1:0]   o_rsp_tag,
    output logic                   o_busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DRAIN,
        S_RESP
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [XLEN-1:0]        r_rs1;
    logic [XLEN-1:0]        r_rs2;
    logic [XLEN-1:0]        r_result;
    rice_core_mul_operation r_op;
    logic [TAG_WIDTH-1:0]   r_tag;
    logic                   w_accept;
    logic                   w_zero;
    logic                   w_capture;

    // A flush in IDLE blocks acceptance so a killed request never starts.
    assign o_req_ready = (r_state == S_IDLE) && !i_flush;
    assign w_accept    = i_req_valid && o_req_ready;
    assign w_zero      = (ZERO_BYPASS != 1'b0) &&
                         ((i_req_rs1 == '0) || (i_req_rs2 == '0));

    // Operands leave through registers so they only change on accept.
    assign o_mul_rs1_value = r_rs1;
    assign o_mul_rs2_value = r_rs2;
    assign o_mul_operation = r_op;
    assign o_rsp_result    = r_result;
    assign o_rsp_tag       = r_tag;

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and state-decoded outputs.
    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        o_mul_valid  = 1'b0;
        o_rsp_valid  = 1'b0;
        o_busy       = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = w_zero ? S_RESP : S_ISSUE;
                end
            end
            S_ISSUE: begin
                o_mul_valid  = 1'b1;
                w_state_next = i_flush ? S_DRAIN : S_WAIT;
            end
            S_WAIT: begin
                if (i_mul_result_valid) begin
                    // A result that coincides with a flush is simply dropped.
                    if (i_flush) begin
                        w_state_next = S_IDLE;
                    end else begin
                        w_capture    = 1'b1;
                        w_state_next = S_RESP;
                    end
                end else if (i_flush) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // The multiplier cannot abort; wait out its completion.
                if (i_mul_result_valid) begin
                    w_state_next = S_IDLE;
                end
            end
            S_RESP: begin
                o_rsp_valid = 1'b1;
                if (i_rsp_ready || i_flush) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Operand, tag and result capture.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rs1    <= '0;
            r_rs2    <= '0;
            r_op     <= '0;
            r_tag    <= '0;
            r_result <= '0;
        end else begin
            if (w_accept) begin
                r_rs1 <= i_req_rs1;
                r_rs2 <= i_req_rs2;
                r_op  <= i_req_operation;
                r_tag <= i_req_tag;
            end
            if (w_accept && w_zero) begin
                r_result <= '0;
            end else if (w_capture) begin
                r_result <= i_mul_result;
            end
        end
    end

endmodule

// File: tb/tb_rice_core_mul_ctrl.sv
// Testbench for rice_core_mul_ctrl: a behavioural multiplier answers start
// pulses after (XLEN+2)/2 cycles; expected responses go into a queue when a
// request is driven and are compared when the DUT presents its response.
// A second instance with the zero bypass disabled shares the stimulus.

module tb_rice_core_mul_ctrl;
    import rice_core_mul_pkg::*;

    localparam int XLEN    = 32;
    localparam int TW      = 5;
    localparam int MUL_LAT = (XLEN + 2) / 2;
    localparam int RSP_LAT = MUL_LAT + 2;

    logic                   i_clk = 1'b0;
    logic                   i_rst;
    logic                   i_req_valid;
    logic                   o_req_ready;
    logic [XLEN-1:0]        i_req_rs1;
    logic [XLEN-1:0]        i_req_rs2;
    rice_core_mul_operation i_req_operation;
    logic [TW-1:0]          i_req_tag;
    logic                   i_flush;
    logic                   o_mul_valid;
    logic [XLEN-1:0]        o_mul_rs1_value;
    logic [XLEN-1:0]        o_mul_rs2_value;
    rice_core_mul_operation o_mul_operation;
    logic                   i_mul_result_valid;
    logic [XLEN-1:0]        i_mul_result;
    logic                   o_rsp_valid;
    logic                   i_rsp_ready;
    logic [XLEN-1:0]        o_rsp_result;
    logic [TW-1:0]          o_rsp_tag;
    logic                   o_busy;

    logic                   nb_req_ready;
    logic                   nb_mul_valid;
    logic [XLEN-1:0]        nb_mul_rs1;
    logic [XLEN-1:0]        nb_mul_rs2;
    rice_core_mul_operation nb_mul_op;
    logic                   nb_res_valid;
    logic [XLEN-1:0]        nb_result;
    logic                   nb_rsp_valid;
    logic [XLEN-1:0]        nb_rsp_result;
    logic [TW-1:0]          nb_rsp_tag;
    logic                   nb_busy;

    always #5 i_clk = ~i_clk;

    rice_core_mul_ctrl #(.XLEN(XLEN), .TAG_WIDTH(TW), .ZERO_BYPASS(1'b1)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_rs1(i_req_rs1), .i_req_rs2(i_req_rs2),
        .i_req_operation(i_req_operation), .i_req_tag(i_req_tag),
        .i_flush(i_flush),
        .o_mul_valid(o_mul_valid), .o_mul_rs1_value(o_mul_rs1_value),
        .o_mul_rs2_value(o_mul_rs2_value), .o_mul_operation(o_mul_operation),
        .i_mul_result_valid(i_mul_result_valid), .i_mul_result(i_mul_result),
        .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
        .o_rsp_result(o_rsp_result), .o_rsp_tag(o_rsp_tag),
        .o_busy(o_busy)
    );

    rice_core_mul_ctrl #(.XLEN(XLEN), .TAG_WIDTH(TW), .ZERO_BYPASS(1'b0)) dut_nb (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_req_valid(i_req_valid), .o_req_ready(nb_req_ready),
        .i_req_rs1(i_req_rs1), .i_req_rs2(i_req_rs2),
        .i_req_operation(i_req_operation), .i_req_tag(i_req_tag),
        .i_flush(i_flush),
        .o_mul_valid(nb_mul_valid), .o_mul_rs1_value(nb_mul_rs1),
        .o_mul_rs2_value(nb_mul_rs2), .o_mul_operation(nb_mul_op),
        .i_mul_result_valid(nb_res_valid), .i_mul_result(nb_result),
        .o_rsp_valid(nb_rsp_valid), .i_rsp_ready(i_rsp_ready),
        .o_rsp_result(nb_rsp_result), .o_rsp_tag(nb_rsp_tag),
        .o_busy(nb_busy)
    );

    typedef struct {
        logic [XLEN-1:0] result;
        logic [TW-1:0]   tag;
        int              rsp_cyc;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   mul_pulses = 0, last_mul_cyc = -1;
    int   nb_mul_pulses = 0, nb_last_mul_cyc = -1;
    int   nb_rsp_cyc = -1;
    logic [XLEN-1:0] nb_rsp_val;
    logic [TW-1:0]   nb_rsp_tg;

    function automatic logic [XLEN-1:0] mul_ref(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                                input rice_core_mul_operation op);
        logic [2*XLEN-1:0] ea, eb, p;
        ea = op.rs1_signed ? {{XLEN{a[XLEN-1]}}, a} : {{XLEN{1'b0}}, a};
        eb = op.rs2_signed ? {{XLEN{b[XLEN-1]}}, b} : {{XLEN{1'b0}}, b};
        p  = ea * eb;
        return op.rd_high ? p[2*XLEN-1:XLEN] : p[XLEN-1:0];
    endfunction

    task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge i_clk) cyc <= cyc + 1;

    // Behavioural multipliers: result strobe MUL_LAT cycles after the start
    // pulse, computed from the operands the controller is holding then.
    int   m_cnt;
    logic m_busy;
    always @(posedge i_clk) begin
        i_mul_result_valid <= 1'b0;
        if (i_rst) begin
            m_busy <= 1'b0;
            m_cnt  <= 0;
        end else if (m_busy) begin
            if (m_cnt == 1) begin
                i_mul_result_valid <= 1'b1;
                i_mul_result       <= mul_ref(o_mul_rs1_value, o_mul_rs2_value, o_mul_operation);
                m_busy             <= 1'b0;
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end else if (o_mul_valid) begin
            m_busy <= 1'b1;
            m_cnt  <= MUL_LAT - 1;
        end
    end

    int   nm_cnt;
    logic nm_busy;
    always @(posedge i_clk) begin
        nb_res_valid <= 1'b0;
        if (i_rst) begin
            nm_busy <= 1'b0;
            nm_cnt  <= 0;
        end else if (nm_busy) begin
            if (nm_cnt == 1) begin
                nb_res_valid <= 1'b1;
                nb_result    <= mul_ref(nb_mul_rs1, nb_mul_rs2, nb_mul_op);
                nm_busy      <= 1'b0;
            end else begin
                nm_cnt <= nm_cnt - 1;
            end
        end else if (nb_mul_valid) begin
            nm_busy <= 1'b1;
            nm_cnt  <= MUL_LAT - 1;
        end
    end

    // Response monitor / scoreboard, sampled on the falling edge.
    initial begin
        logic prev_rsp = 1'b0;
        logic nb_prev  = 1'b0;
        forever begin
            @(negedge i_clk);
            if (o_mul_valid) begin mul_pulses++; last_mul_cyc = cyc; end
            if (nb_mul_valid) begin nb_mul_pulses++; nb_last_mul_cyc = cyc; end
            if (nb_rsp_valid && !nb_prev) begin
                nb_rsp_cyc = cyc; nb_rsp_val = nb_rsp_result; nb_rsp_tg = nb_rsp_tag;
            end
            nb_prev = nb_rsp_valid;
            if (o_rsp_valid) begin
                if (sb_q.size() == 0) begin
                    check_eq("rsp_unexpected", 64'd1, 64'd0);
                end else begin
                    if (!prev_rsp) check_eq("rsp_latency", cyc, sb_q[0].rsp_cyc);
                    check_eq("rsp_result", o_rsp_result, sb_q[0].result);
                    check_eq("rsp_tag", o_rsp_tag, sb_q[0].tag);
                    if (i_rsp_ready) begin
                        $display("RSP tag=%0d result=0x%08h cycle=%0d", o_rsp_tag, o_rsp_result, cyc);
                        void'(sb_q.pop_front());
                    end
                end
            end
            prev_rsp = o_rsp_valid;
        end
    end

    // Drives a request from just after a rising edge until it is accepted.
    task automatic send_req(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                            input rice_core_mul_operation op, input logic [TW-1:0] tag,
                            input bit expect_rsp, input int lat, input logic [XLEN-1:0] exp_res,
                            output int t_acc);
        int n = 0;
        i_req_valid = 1'b1; i_req_rs1 = a; i_req_rs2 = b;
        i_req_operation = op; i_req_tag = tag;
        do begin @(negedge i_clk); n++; end while (!o_req_ready && n < 200);
        if (!o_req_ready) check_eq("req_accept_timeout", 64'd0, 64'd1);
        t_acc = cyc;
        $display("REQ tag=%0d rs1=0x%08h rs2=0x%08h op=%03b accept_cycle=%0d", tag, a, b, op, cyc);
        if (expect_rsp) sb_q.push_back('{exp_res, tag, cyc + lat});
        @(posedge i_clk); #1;
        i_req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin @(negedge i_clk); n++; end
        while ((o_busy || nb_busy || sb_q.size() != 0) && n < 300);
        if (o_busy || nb_busy || sb_q.size() != 0) check_eq("idle_timeout", 64'd0, 64'd1);
        @(posedge i_clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d required below 20000", cyc);
        $fatal(1);
    end

    initial begin
        int t, t2, base, nb_base, n;
        logic [XLEN-1:0] ra, rb;
        rice_core_mul_operation rop;
        i_rst = 1'b1; i_req_valid = 1'b0; i_req_rs1 = '0; i_req_rs2 = '0;
        i_req_operation = '0; i_req_tag = '0; i_flush = 1'b0; i_rsp_ready = 1'b1;
        repeat (3) @(posedge i_clk);
        #1 i_rst = 1'b0;

        // Reset state
        @(negedge i_clk);
        check_eq("rst_busy", o_busy, 0);
        check_eq("rst_rsp_valid", o_rsp_valid, 0);
        check_eq("rst_mul_valid", o_mul_valid, 0);
        check_eq("rst_req_ready", o_req_ready, 1);
        check_eq("rst_nb_req_ready", nb_req_ready, 1);
        check_eq("rst_rs1", o_mul_rs1_value, 0);
        check_eq("rst_rs2", o_mul_rs2_value, 0);
        check_eq("rst_op", o_mul_operation, 0);
        check_eq("rst_result", o_rsp_result, 0);
        check_eq("rst_tag", o_rsp_tag, 0);
        @(posedge i_clk); #1;

        // Unsigned MUL
        base = mul_pulses;
        send_req(32'h7, 32'h6, 3'b000, 5'd3, 1'b1, RSP_LAT, 32'h2A, t);
        wait_idle();
        check_eq("mul_pulse_count", mul_pulses - base, 1);
        check_eq("mul_pulse_cycle", last_mul_cyc, t + 1);

        // MULH and MULHU
        send_req(32'hFFFF_FFFF, 32'h8000_0000, 3'b111, 5'd4, 1'b1, RSP_LAT, 32'h0, t);
        wait_idle();
        send_req(32'hFFFF_FFFF, 32'h8000_0000, 3'b001, 5'd5, 1'b1, RSP_LAT, 32'h7FFF_FFFF, t);
        wait_idle();

        // Zero bypass versus no-bypass instance
        base = mul_pulses; nb_base = nb_mul_pulses;
        send_req(32'h0, 32'h1234_5678, 3'b000, 5'd9, 1'b1, 1, 32'h0, t);
        wait_idle();
        check_eq("byp_no_mul", mul_pulses - base, 0);
        check_eq("nobyp_mul_count", nb_mul_pulses - nb_base, 1);
        check_eq("nobyp_mul_cycle", nb_last_mul_cyc, t + 1);
        check_eq("nobyp_rsp_cycle", nb_rsp_cyc, t + RSP_LAT);
        check_eq("nobyp_rsp_result", nb_rsp_val, 0);
        check_eq("nobyp_rsp_tag", nb_rsp_tg, 9);
        send_req(32'h0000_ABCD, 32'h0, 3'b101, 5'd10, 1'b1, 1, 32'h0, t);
        wait_idle();

        // A few random operand/operation mixes
        for (int i = 0; i < 4; i++) begin
            ra  = $urandom;
            rb  = (i == 2) ? 32'h0 : $urandom;
            rop = 3'($urandom_range(0, 7));
            send_req(ra, rb, rop, 5'(11 + i), 1'b1, (ra == 0 || rb == 0) ? 1 : RSP_LAT,
                     mul_ref(ra, rb, rop), t);
            wait_idle();
        end

        // Flush with a valid request in IDLE: not accepted
        i_req_valid = 1'b1; i_req_rs1 = 32'h3; i_req_rs2 = 32'h4; i_req_tag = 5'd30; i_flush = 1'b1;
        @(negedge i_clk);
        check_eq("flush_idle_ready", o_req_ready, 0);
        @(posedge i_clk); #1;
        i_req_valid = 1'b0; i_flush = 1'b0;
        @(negedge i_clk);
        check_eq("flush_idle_busy", o_busy, 0);
        @(posedge i_clk); #1;

        // Flush in WAIT: drain until the multiplier finishes, no response
        send_req(32'h11, 32'h22, 3'b000, 5'd7, 1'b0, 0, 32'h0, t);
        while (cyc < t + 5) begin @(posedge i_clk); #1; end
        i_flush = 1'b1;
        @(posedge i_clk); #1;
        i_flush = 1'b0;
        repeat (MUL_LAT - 4) begin
            @(negedge i_clk);
            check_eq("drain_ready", o_req_ready, 0);
            check_eq("drain_rs1", o_mul_rs1_value, 32'h11);
            check_eq("drain_rs2", o_mul_rs2_value, 32'h22);
        end
        @(negedge i_clk);
        check_eq("drain_done_cycle", cyc, t + RSP_LAT);
        check_eq("drain_done_ready", o_req_ready, 1);
        @(posedge i_clk); #1;

        // Backpressure: response held 10 cycles, next request waits for handshake
        i_rsp_ready = 1'b0;
        send_req(32'd1000, 32'd3000, 3'b000, 5'd12, 1'b1, RSP_LAT, 32'd3000000, t);
        n = 0;
        do begin @(negedge i_clk); n++; end while (!o_rsp_valid && n < 100);
        check_eq("bp_rsp_seen", o_rsp_valid, 1);
        @(posedge i_clk); #1;
        i_req_valid = 1'b1; i_req_rs1 = 32'd5; i_req_rs2 = 32'd9;
        i_req_operation = 3'b000; i_req_tag = 5'd13;
        repeat (9) begin
            @(negedge i_clk);
            check_eq("bp_ready_low", o_req_ready, 0);
            @(posedge i_clk); #1;
        end
        i_rsp_ready = 1'b1;
        @(negedge i_clk);
        check_eq("bp_ready_at_handshake", o_req_ready, 0);
        t2 = cyc + 1;
        sb_q.push_back('{32'd45, 5'd13, t2 + RSP_LAT});
        @(posedge i_clk); #1;
        @(negedge i_clk);
        check_eq("bp_ready_after_handshake", o_req_ready, 1);
        $display("REQ tag=13 rs1=0x00000005 rs2=0x00000009 op=000 accept_cycle=%0d", cyc);
        @(posedge i_clk); #1;
        i_req_valid = 1'b0;
        wait_idle();
        check_eq("bp_next_mul_cycle", last_mul_cyc, t2 + 1);

        // Reset in the middle of WAIT aborts silently
        send_req(32'd123, 32'd456, 3'b000, 5'd20, 1'b0, 0, 32'h0, t);
        while (cyc < t + 8) begin @(posedge i_clk); #1; end
        i_rst = 1'b1;
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        @(negedge i_clk);
        check_eq("midrst_busy", o_busy, 0);
        check_eq("midrst_rsp_valid", o_rsp_valid, 0);
        check_eq("midrst_mul_valid", o_mul_valid, 0);
        check_eq("midrst_req_ready", o_req_ready, 1);
        @(posedge i_clk); #1;
        send_req(32'd123, 32'd456, 3'b000, 5'd21, 1'b1, RSP_LAT, 32'd56088, t);
        wait_idle();

        check_eq("sb_empty", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rice_core_mul_ctrl.md
Name: rice_core_mul_ctrl

Overview:
Sequencer in front of the iterative radix-4 multiplier (rice_core_mul) in the execute stage. It accepts M-extension multiply requests over a valid/ready handshake and registers the operands. It issues a single start pulse to the multiplier and holds the operands stable for the whole iteration. It returns the result with the request tag over a valid/ready response port, and handles pipeline flush and a zero-operand bypass.

Parameters:
XLEN, 32, operand/result width; must match the multiplier.
TAG_WIDTH, 5, width of the opaque request tag (e.g. rd index).
ZERO_BYPASS, 1, 1 = a request with a zero operand completes without using the multiplier.

Ports:
i_clk  input  1  clock
i_rst  input  1  synchronous reset, active-high
i_req_valid  input  1  request valid
o_req_ready  output  1  request accepted when valid && ready
i_req_rs1  input  XLEN  multiplicand
i_req_rs2  input  XLEN  multiplier operand
i_req_operation  input  rice_core_mul_operation  {rs1_signed, rs2_signed, rd_high}
i_req_tag  input  TAG_WIDTH  opaque tag, returned with the result
i_flush  input  1  kill in-flight and pending work
o_mul_valid  output  1  start pulse to the multiplier
o_mul_rs1_value  output  XLEN  held rs1 to the multiplier
o_mul_rs2_value  output  XLEN  held rs2 to the multiplier
o_mul_operation  output  rice_core_mul_operation  held operation to the multiplier
i_mul_result_valid  input  1  multiplier completion strobe
i_mul_result  input  XLEN  multiplier result
o_rsp_valid  output  1  response valid
i_rsp_ready  input  1  response consumed when valid && ready
o_rsp_result  output  XLEN  product half selected by rd_high
o_rsp_tag  output  TAG_WIDTH  tag of the request
o_busy  output  1  state != IDLE

Behaviour:
- Reset (i_rst=1 at posedge):
  - state=IDLE.
  - o_mul_valid=0, o_rsp_valid=0, o_busy=0.
  - Operand, tag and result registers = 0.
  - o_req_ready=1 once i_rst is low.
  - i_rst and the multiplier reset are asserted together. A reset in any state aborts all work, and no response is produced.
- States: IDLE, ISSUE, WAIT, DRAIN, RESP.
- o_req_ready = (state==IDLE) && !i_flush. A flush and a valid request in the same cycle means the request is not accepted.
- IDLE, on accept:
  - Register rs1, rs2, operation and tag.
  - If ZERO_BYPASS and (rs1==0 or rs2==0): result register=0, go to RESP.
  - Otherwise go to ISSUE.
- ISSUE:
  - o_mul_valid=1 for exactly this one cycle; the multiplier is guaranteed idle here.
  - Go to WAIT, or to DRAIN if i_flush.
- WAIT:
  - o_mul_valid=0, operands held.
  - On i_mul_result_valid: capture i_mul_result, go to RESP.
  - On i_flush without a result this cycle: go to DRAIN.
  - Flush and result in the same cycle: discard the result, go to IDLE.
- DRAIN:
  - Operands stay held, because the multiplier cannot abort and reads its operands every cycle.
  - On i_mul_result_valid: discard, go to IDLE. i_flush has no further effect.
- RESP:
  - o_rsp_valid=1; o_rsp_result and o_rsp_tag are stable until handshake.
  - On i_rsp_ready: go to IDLE. The next request is accepted no earlier than the following cycle.
  - On i_flush: o_rsp_valid drops next cycle, go to IDLE. Flush and ready in the same cycle count as consumed.
- o_mul_* operand outputs change only on accept. They are held through ISSUE, WAIT, DRAIN and RESP.
- i_mul_result_valid in IDLE, ISSUE or RESP is ignored.
- Latency, accept at cycle T:
  - Multiplied request: o_mul_valid at T+1, i_mul_result_valid at T+1+(XLEN+2)/2, o_rsp_valid at T+2+(XLEN+2)/2 (T+19 for XLEN=32).
  - Bypassed request: o_rsp_valid at T+1.
- Throughput: one request in flight; no overlap between a response and the next issue.

Test Plan:
- Unsigned MUL: rs1=0x0000_0007, rs2=0x0000_0006, op={0,0,0}, tag=3 -> one o_mul_valid pulse at T+1; o_rsp_valid at T+19; result=0x0000_002A; tag=3.
- Signed MULH: rs1=0xFFFF_FFFF, rs2=0x8000_0000, op={1,1,1} -> result=0x0000_0000. MULHU with the same operands, op={0,0,1} -> result=0x7FFF_FFFF.
- Zero bypass: rs1=0, rs2=0x1234_5678 -> no o_mul_valid; o_rsp_valid at T+1; result=0. With ZERO_BYPASS=0 -> issued normally, result=0 at T+19.
- Flush in WAIT at T+5 -> o_req_ready stays 0 and operands stay stable until i_mul_result_valid at T+18; no response; o_req_ready=1 at T+19.
- Backpressure: i_rsp_ready=0 for 10 cycles in RESP -> result and tag stable; o_req_ready=0; a new request is accepted only the cycle after the handshake.
- Reset mid-WAIT (i_rst=1 for 1 cycle at T+8) -> next cycle IDLE, o_busy=0, o_rsp_valid=0, o_mul_valid=0; a following request completes with a correct result.
